// File: rtl/wiener_frame_scheduler.sv
// wiener_frame_scheduler: buffers an upstream pixel stream and emits gapless per-block bursts
// framed by start/end-of-frame for the non-stallable Wiener statistics datapath.
module wiener_frame_scheduler #(
  parameter int DATA_WIDTH    = 8,
  parameter int TOTAL_SAMPLES = 8,
  parameter int FIFO_BLOCKS   = 2,
  parameter int DRAIN_TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frame_start_req,
  input  logic [31:0]           blocks_per_frame,
  input  logic                  pix_valid,
  input  logic [DATA_WIDTH-1:0] pix_data,
  output logic                  pix_ready,
  input  logic                  variance_ready,
  output logic                  start_of_frame,
  output logic                  end_of_frame,
  output logic                  start_data,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  err
);
  localparam int DEPTH = FIFO_BLOCKS * TOTAL_SAMPLES;
  localparam int LW    = $clog2(TOTAL_SAMPLES);
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int TW    = $clog2(DRAIN_TIMEOUT + 1);
  localparam int ACW   = 32 + LW;
  typedef enum logic [2:0] {IDLE, SOF, FILL, BURST, DRAIN, EOF} state_t;
  state_t          state_q, state_d;
  logic [31:0]     bpf_q, bpf_d, blk_q, blk_d, vr_q, vr_d;
  logic [ACW-1:0]  acc_q, acc_d;
  logic [LW-1:0]   beat_q, beat_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   wp_q, wp_d, rp_q, rp_d;
  logic            err_q, err_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic            wr, rd;
  assign pix_ready = (state_q == FILL || state_q == BURST) && cnt_q < CW'(DEPTH)
                     && acc_q < {bpf_q, {LW{1'b0}}};
  assign wr = pix_valid && pix_ready;
  assign rd = state_q == BURST;
  assign start_of_frame = state_q == SOF;
  assign end_of_frame   = state_q == EOF;
  assign frame_done     = state_q == EOF;
  assign start_data     = rd && beat_q == '0;
  assign data_out       = rd ? mem_q[rp_q] : '0;
  assign busy           = state_q != IDLE;
  assign err            = err_q;
  always_comb begin
    state_d = state_q;
    bpf_d   = bpf_q;
    blk_d   = blk_q;
    beat_d  = beat_q;
    err_d   = err_q || (frame_start_req && state_q != IDLE);
    acc_d   = acc_q + ACW'(wr);
    cnt_d   = cnt_q + CW'(wr) - CW'(rd);
    wp_d    = wr ? (wp_q == AW'(DEPTH - 1) ? '0 : wp_q + AW'(1)) : wp_q;
    rp_d    = rd ? (rp_q == AW'(DEPTH - 1) ? '0 : rp_q + AW'(1)) : rp_q;
    vr_d    = (state_q != IDLE && variance_ready && vr_q < bpf_q) ? vr_q + 32'd1 : vr_q;
    tmr_d   = state_q == DRAIN ? tmr_q + TW'(1) : '0;
    case (state_q)
      IDLE: if (frame_start_req) begin
        state_d = SOF;
        bpf_d   = blocks_per_frame;
        acc_d   = '0;
        blk_d   = '0;
        vr_d    = '0;
        beat_d  = '0;
        err_d   = 1'b0;
      end
      SOF:  state_d = bpf_q == '0 ? EOF : FILL;
      FILL: state_d = cnt_d >= CW'(TOTAL_SAMPLES) ? BURST : FILL;
      BURST: begin
        beat_d = beat_q + LW'(1);
        if (beat_q == LW'(TOTAL_SAMPLES - 1)) begin
          blk_d   = blk_q + 32'd1;
          state_d = blk_d == bpf_q ? DRAIN : cnt_d >= CW'(TOTAL_SAMPLES) ? BURST : FILL;
        end
      end
      DRAIN: if (vr_d == bpf_q) state_d = EOF;
        else if (tmr_q == TW'(DRAIN_TIMEOUT - 1)) begin
          state_d = EOF;
          err_d   = 1'b1;
        end
      EOF:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      bpf_q   <= '0;
      blk_q   <= '0;
      vr_q    <= '0;
      acc_q   <= '0;
      beat_q  <= '0;
      tmr_q   <= '0;
      cnt_q   <= '0;
      wp_q    <= '0;
      rp_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bpf_q   <= bpf_d;
      blk_q   <= blk_d;
      vr_q    <= vr_d;
      acc_q   <= acc_d;
      beat_q  <= beat_d;
      tmr_q   <= tmr_d;
      cnt_q   <= cnt_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      err_q   <= err_d;
    end
  always_ff @(posedge clk)
    if (wr) mem_q[wp_q] <= pix_data;
endmodule
